// File: rtl/skewed_weight_fifo_if.sv
// Weight-stream bundle: AXI4-S write side, pop request, skewed lane outputs and status.
interface skewed_weight_fifo_if #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = 8,
  parameter int DEPTH   = 1024
) ();
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                        s_axis_valid;
  logic [N_LANES*LANE_W-1:0]   s_axis_data;
  logic                        s_axis_last;
  logic                        s_axis_ready;
  logic                        rd_en;
  logic [N_LANES*LANE_W-1:0]   out_data;
  logic [N_LANES-1:0]          out_valid;
  logic [LVL_W-1:0]            level;
  logic                        full;
  logic                        empty;
  logic                        tile_done;

  modport slave (
    input  s_axis_valid, s_axis_data, s_axis_last, rd_en,
    output s_axis_ready, out_data, out_valid, level, full, empty, tile_done
  );

  modport master (
    output s_axis_valid, s_axis_data, s_axis_last, rd_en,
    input  s_axis_ready, out_data, out_valid, level, full, empty, tile_done
  );
endinterface

// File: rtl/skewed_weight_fifo.sv
// Weight FIFO feeding a systolic array edge: each popped word leaves lane k
// delayed by k extra cycles, with the tile's last flag riding the final lane.
module skewed_weight_lane #(
  parameter int W      = 8,
  parameter int STAGES = 1
) (
  input  logic         axi_clk,
  input  logic         axi_rst_n,
  input  logic [W-1:0] d,
  input  logic         v,
  output logic [W-1:0] q,
  output logic         qv
);
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][W-1:0] dat_pipe;

  // Invalid slots carry zero so idle lanes read as 0 downstream.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], v};
      dat_pipe <= {dat_pipe[STAGES-1:0], (v ? d : W'(0))};
    end
  end

  assign q  = dat_pipe[STAGES];
  assign qv = vld_pipe[STAGES];
endmodule

module skewed_weight_fifo #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = 8,
  parameter int DEPTH   = 1024
) (
  input  logic               axi_clk,
  input  logic               axi_rst_n,
  skewed_weight_fifo_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef struct packed {
    logic                           last;
    logic [N_LANES-1:0][LANE_W-1:0] data;
  } word_t;

  word_t                          mem [DEPTH];
  word_t                          rd_word;
  logic [AW-1:0]                  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]               level_q, level_nxt;
  logic                           full_q, empty_q;
  logic                           push, pop;
  logic [N_LANES-1:0][LANE_W-1:0] lane_q;
  logic [N_LANES-1:0]             lane_v;
  logic                           tail_last;

  assign push = bus.s_axis_valid & ~full_q;
  assign pop  = bus.rd_en & ~empty_q;

  assign bus.s_axis_ready = ~full_q;
  assign bus.level        = level_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;

  always_comb begin
    level_nxt = level_q;
    if (push && !pop)      level_nxt = level_q + LVL_W'(1);
    else if (pop && !push) level_nxt = level_q - LVL_W'(1);
  end

  // Flags are derived from the next level so they stay registered yet current.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_W'(DEPTH));
      empty_q <= (level_nxt == '0);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_ptr] <= word_t'({bus.s_axis_last, bus.s_axis_data});
  end

  assign rd_word = mem[rd_ptr];

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    if (k == N_LANES - 1) begin : g_tail
      logic [LANE_W:0] q;
      skewed_weight_lane #(.W(LANE_W + 1), .STAGES(k + 1)) u_lane (
        .axi_clk   (axi_clk),
        .axi_rst_n (axi_rst_n),
        .d         ({rd_word.last, rd_word.data[k]}),
        .v         (pop),
        .q         (q),
        .qv        (lane_v[k])
      );
      assign lane_q[k]  = q[LANE_W-1:0];
      assign tail_last  = q[LANE_W];
    end else begin : g_body
      skewed_weight_lane #(.W(LANE_W), .STAGES(k + 1)) u_lane (
        .axi_clk   (axi_clk),
        .axi_rst_n (axi_rst_n),
        .d         (rd_word.data[k]),
        .v         (pop),
        .q         (lane_q[k]),
        .qv        (lane_v[k])
      );
    end
  end

  assign bus.out_data  = lane_q;
  assign bus.out_valid = lane_v;
  assign bus.tile_done = tail_last;
endmodule
